lcd_write_engine: RTL
=====================

// Module: lcd_write_engine
// PURPOSE
//  Responder side of the wr_enable/wr_finish handshake used by the LCD init/refresh sequencer.
//  Latches one byte plus RS and drives HD44780-style bus timing: setup, E pulse, hold, execution wait.
//  Then pulses wr_finish.
//  Sits between the sequencer/mux and the LCD pins; the only block that toggles lcd_e.
// PARAMETERS
//  NIBBLE_MODE    0      1: 4-bit bus, byte sent high nibble then low nibble on lcd_db[7:4]
//  SETUP_CYC      3      cycles RS/DB stable before E rises (>=1)
//  E_HIGH_CYC     12     cycles E held high (>=1)
//  HOLD_CYC       1      cycles RS/DB held after E falls (>=1)
//  NIBBLE_GAP_CYC 50     cycles between nibble transfers (NIBBLE_MODE=1 only, >=1)
//  EXEC_CYC       2000   command/data execution wait (40us @50MHz)
//  LONG_EXEC_CYC  82000  execution wait for clear/home (1.64ms @50MHz)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous, active-low reset
//  wr_enable  in   1  start request, sampled only in IDLE; 1-cycle pulse expected
//  rs_in      in   1  0=command, 1=data
//  data_in    in   8  byte to write, captured with wr_enable
//  wr_finish  out  1  1-cycle pulse: transfer plus execution wait complete
//  busy       out  1  high from cycle after accept until wr_finish cycle (exclusive)
//  lcd_e      out  1  LCD enable strobe
//  lcd_rs     out  1  LCD register select
//  lcd_rw     out  1  tied 0 (write-only)
//  lcd_db     out  8  LCD data bus; in NIBBLE_MODE [3:0] driven 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, counter 0; all outputs 0; lcd_e drops immediately.
//  Reset mid-transfer aborts with no wr_finish.
//  All outputs are registered.
//  FSM states: IDLE, SETUP, E_HIGH, HOLD, GAP, EXEC, DONE.
//   IDLE:   wr_enable=1 -> latch rs_in/data_in into lcd_rs/lcd_db (or high nibble) -> SETUP.
//   SETUP:  SETUP_CYC cycles -> E_HIGH.
//   E_HIGH: lcd_e=1 for E_HIGH_CYC cycles -> HOLD.
//   HOLD:   lcd_e=0, bus stable for HOLD_CYC cycles.
//           Then -> GAP if NIBBLE_MODE and first nibble; otherwise -> EXEC.
//   GAP:    drive low nibble on lcd_db[7:4] for NIBBLE_GAP_CYC cycles -> SETUP (second nibble).
//   EXEC:   wait LONG_EXEC_CYC if rs=0 and byte[7:2]==0 and byte!=0, i.e. 0x01..0x03.
//           Otherwise wait EXEC_CYC. Then -> DONE.
//   DONE:   wr_finish=1 for exactly one cycle -> IDLE.
//  Latency, 8-bit mode: wr_finish is high in cycle L = 1 + SETUP + E_HIGH + HOLD + EXEC_sel.
//   L is counted after the clk edge that samples wr_enable.
//   Nibble mode adds SETUP + E_HIGH + HOLD + NIBBLE_GAP.
//  lcd_rs/lcd_db are unchanged from capture until the next accept, so they are stable across E.
//  wr_enable outside IDLE (busy or DONE) is ignored, not queued. The sequencer must wait for wr_finish.
//  wr_enable in the cycle after wr_finish (back in IDLE) is accepted normally.
//  Counter: one down-counter sized for $clog2(max of all *_CYC)+1.
//   Loaded with N-1 on state entry; leaves the state when it reads 0. No wrap-around.
//  Illegal state encodings recover to IDLE.
// STRUCTURE
//  lcd_pkg: state encoding localparams, LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02, long-cmd decode function.
//  Sub-module lcd_delay_counter: load/value/zero flag. Shared with the power-on init delay logic.
// TESTING (SETUP=2, E_HIGH=3, HOLD=1, EXEC=4, LONG=10, GAP=2)
//  1. rst_n=0 mid-E_HIGH -> lcd_e=0 same cycle, busy=0, no wr_finish; next accept works.
//  2. wr_enable, rs=1, data=8'h41 (8-bit) -> lcd_db=41, rs=1, lcd_e high 3 cycles.
//     E rises 3 cycles after accept edge; wr_finish in cycle 11, 1 cycle wide.
//  3. rs=0, data=8'h01 -> LONG wait, wr_finish in cycle 17.
//     rs=1, data=8'h01 -> short wait, cycle 11.
//  4. NIBBLE_MODE=1, data=8'hA5 -> two E pulses carrying db[7:4]=A then 5.
//     Pulses separated by HOLD+GAP+SETUP; wr_finish in cycle 19.
//  5. wr_enable pulsed while busy -> ignored; outputs and wr_finish timing unchanged.
//  6. Back-to-back: wr_enable the cycle after wr_finish -> accepted; no lost or duplicate E pulses.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: write-engine state encoding, command codes and
// the decode for commands that need the long execution wait.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_E_HIGH = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4,
    ST_EXEC   = 3'd5,
    ST_DONE   = 3'd6
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) run for ~1.64 ms.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd);
    return !rs && ((cmd == LCD_CMD_CLEAR) || (cmd[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

  function automatic int cyc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that stops at zero; used for every LCD timing wait.
module lcd_delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 write engine: accepts one byte on wr_enable, sequences setup / E pulse /
// hold (twice in 4-bit mode), waits out the execution time, then pulses wr_finish.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int NIBBLE_MODE    = 0,
  parameter int SETUP_CYC      = 3,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 1,
  parameter int NIBBLE_GAP_CYC = 50,
  parameter int EXEC_CYC       = 2000,
  parameter int LONG_EXEC_CYC  = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_enable,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       wr_finish,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  localparam bit NIB     = (NIBBLE_MODE != 0);
  localparam int MAX_CYC = cyc_max(cyc_max(cyc_max(SETUP_CYC, E_HIGH_CYC),
                                           cyc_max(HOLD_CYC, NIBBLE_GAP_CYC)),
                                   cyc_max(EXEC_CYC, LONG_EXEC_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EHIGH = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_EXEC_CYC - 1);

  lcd_state_t       state_q, state_nx;
  logic             second_q;
  logic [7:0]       byte_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_ld_val;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  lcd_delay_counter #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nx   = state_q;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    case (state_q)
      ST_IDLE: if (wr_enable) begin
        state_nx   = ST_SETUP;
        cnt_load   = 1'b1;
        cnt_ld_val = LD_SETUP;
      end
      ST_SETUP: if (cnt_zero) begin
        state_nx   = ST_E_HIGH;
        cnt_load   = 1'b1;
        cnt_ld_val = LD_EHIGH;
      end
      ST_E_HIGH: if (cnt_zero) begin
        state_nx   = ST_HOLD;
        cnt_load   = 1'b1;
        cnt_ld_val = LD_HOLD;
      end
      ST_HOLD: if (cnt_zero) begin
        cnt_load = 1'b1;
        if (NIB && !second_q) begin
          state_nx   = ST_GAP;
          cnt_ld_val = LD_GAP;
        end else begin
          state_nx   = ST_EXEC;
          cnt_ld_val = is_long_cmd(lcd_rs, byte_q) ? LD_LONG : LD_EXEC;
        end
      end
      ST_GAP: if (cnt_zero) begin
        state_nx   = ST_SETUP;
        cnt_load   = 1'b1;
        cnt_ld_val = LD_SETUP;
      end
      ST_EXEC: if (cnt_zero) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      second_q  <= 1'b0;
      byte_q    <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= '0;
      busy      <= 1'b0;
      wr_finish <= 1'b0;
    end else begin
      state_q   <= state_nx;
      lcd_e     <= (state_nx == ST_E_HIGH);
      wr_finish <= (state_nx == ST_DONE);
      busy      <= state_nx inside {ST_SETUP, ST_E_HIGH, ST_HOLD, ST_GAP, ST_EXEC};
      if (state_q == ST_IDLE && wr_enable) begin
        byte_q   <= data_in;
        lcd_rs   <= rs_in;
        second_q <= 1'b0;
        lcd_db   <= NIB ? {data_in[7:4], 4'h0} : data_in;
      end
      if (state_q == ST_HOLD && state_nx == ST_GAP) begin
        second_q <= 1'b1;
        lcd_db   <= {byte_q[3:0], 4'h0};
      end
    end
  end

  assign lcd_rw = 1'b0;

endmodule
